game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Frame-synchronous game sequencer that drives the 2-bit game_state selector consumed by gmae_management's VGA pixel datapath.
- Debounces the start button and latches game events (point, hit).
- Advances TITLE -> COUNTDOWN -> PLAY -> OVER only on frame boundaries, so the display never switches scene mid-frame.
- Owns the score register shown by the renderer.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable i_clk cycles required to accept a button level (2.5 ms at 100 MHz).
- COUNTDOWN_FRAMES, 180, frames spent in COUNTDOWN (>=1).
- OVER_FRAMES, 300, frames spent in OVER before auto-return to TITLE (>=1).
- SCORE_W, 8, score width.
- FCNT_W (localparam), $clog2(max(COUNTDOWN_FRAMES, OVER_FRAMES)+1), frame counter width.

Ports:
- i_clk, in, 1, system clock (100 MHz).
- RST_BTN, in, 1, asynchronous active-low reset.
- i_start_btn, in, 1, raw asynchronous button, active-high.
- i_frame_tick, in, 1, one-cycle pulse per frame at start of vblank, from VGA timing.
- i_point, in, 1, one-cycle score-increment pulse from game logic.
- i_hit, in, 1, collision level/pulse from game logic.
- o_game_state, out, 2, 00 TITLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.
- o_state_chg, out, 1, one-cycle pulse in the first cycle a new o_game_state is visible.
- o_frames_left, out, FCNT_W, remaining frames in COUNTDOWN/OVER; 0 otherwise.
- o_score, out, SCORE_W, current score.
- o_paused, out, 1, pause flag (see Optional Feature).

Behaviour:

Reset (RST_BTN=0, async):
- o_game_state=00, o_state_chg=0, o_frames_left=0, o_score=0, o_paused=0.
- Synchronizer, debounce counter and debounced level cleared to 0 (button released).
- press_pend=0, hit_pend=0.
- Reset asserted mid-game aborts immediately to TITLE; no o_state_chg pulse on reset release.

Button:
- 2-flop synchronizer, then debounce.
- Debounced level updates only after DEBOUNCE_CYCLES consecutive cycles of a synchronized value that differs from it. Any bounce restarts the count.
- Rising edge of the debounced level sets press_pend.

Event latches:
- hit_pend sets on any cycle with i_hit=1 while state=PLAY (and not paused).
- hit_pend is forced to 0 whenever state!=PLAY.

Decisions:
- Evaluated only in cycles with i_frame_tick=1.
- New state registered at that clock edge, so it is visible 1 cycle after the tick; o_state_chg=1 in that same cycle.
- press_pend and hit_pend are cleared on every tick, whether consumed or ignored; stale events never carry across frames.
- TITLE: press_pend -> COUNTDOWN; frames_left=COUNTDOWN_FRAMES-1; score=0.
- COUNTDOWN: frames_left==0 -> PLAY; else frames_left-1. Presses are ignored.
- PLAY: hit_pend -> OVER; frames_left=OVER_FRAMES-1. Otherwise stay.
- OVER: press_pend or frames_left==0 -> TITLE; frames_left=0. Otherwise frames_left-1.

Score:
- i_point counts in any cycle while state=PLAY (not frame-gated).
- Saturates at 2^SCORE_W-1; no wrap.
- If i_point and i_hit arrive in the same cycle, the point still counts.
- Score holds through OVER and TITLE; it clears only on entry to COUNTDOWN or on reset.

Other:
- Ticks arriving on consecutive cycles are each evaluated normally.
- i_frame_tick asserted during reset is ignored.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - press_pend at a tick in PLAY toggles o_paused, unless hit_pend is also set; hit wins, the state goes to OVER and o_paused is cleared.
  - While paused: i_point is ignored, hit_pend is held 0, and the state stays PLAY.
  - o_paused is cleared on leaving PLAY and on reset.
- Not defined:
  - o_paused is tied 0.
  - Presses in PLAY are discarded at the tick.

Test Plan (DEBOUNCE_CYCLES=4, COUNTDOWN_FRAMES=3, OVER_FRAMES=5, SCORE_W=4):
- Reset/title: RST_BTN low then high, ticks every 20 cycles, no inputs -> o_game_state stays 00, o_score=0, no o_state_chg pulses.
- Debounce: button toggles with 1–3 cycle glitches, then held high 10 cycles -> exactly one press accepted; the next tick moves to 01 with o_frames_left=2, and o_state_chg pulses once.
- Countdown/play: from 01, three ticks -> o_frames_left 2,1,0, then the third tick enters 10. Press during COUNTDOWN -> ignored.
- Score saturation: 20 i_point pulses in PLAY -> o_score=15. i_point in TITLE -> no change.
- Hit/over timing: i_hit together with i_point in PLAY -> score+1, and the next tick enters 11 with o_frames_left=4. Five ticks with no press -> 00. Repeat with a press mid-OVER -> 00 at the next tick.
- Async reset mid-PLAY with score 7 -> immediately 00, score 0. With GAME_PAUSE_EN: press in PLAY -> o_paused=1 and i_point/i_hit are ignored; a second press -> o_paused=0.

Source files
------------

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - frame-synchronous TITLE/COUNTDOWN/PLAY/OVER sequencer with debounced start and score
// Optional pause-in-PLAY support is enabled by defining GAME_PAUSE_EN.
module game_state_ctrl #(
  parameter  int DEBOUNCE_CYCLES  = 250000,
  parameter  int COUNTDOWN_FRAMES = 180,
  parameter  int OVER_FRAMES      = 300,
  parameter  int SCORE_W          = 8,
  localparam int FCNT_MAX = (COUNTDOWN_FRAMES > OVER_FRAMES) ? COUNTDOWN_FRAMES : OVER_FRAMES,
  localparam int FCNT_W   = $clog2(FCNT_MAX + 1)
) (
  input  logic               i_clk,
  input  logic               RST_BTN,
  input  logic               i_start_btn,
  input  logic               i_frame_tick,
  input  logic               i_point,
  input  logic               i_hit,
  output logic [1:0]         o_game_state,
  output logic               o_state_chg,
  output logic [FCNT_W-1:0]  o_frames_left,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_paused
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCNT_W-1:0]  CD_INIT   = FCNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  OV_INIT   = FCNT_W'(OVER_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_TITLE     = 2'b00,
    S_COUNTDOWN = 2'b01,
    S_PLAY      = 2'b10,
    S_OVER      = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               db_lvl_q, db_lvl_d;
  logic               press_pend_q, press_pend_d;
  logic               hit_pend_q, hit_pend_d;
  logic               state_chg_q, state_chg_d;
  logic [FCNT_W-1:0]  frames_q, frames_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               db_rise;
  logic               paused;

`ifdef GAME_PAUSE_EN
  logic paused_q, paused_d;
  assign paused = paused_q;
`else
  assign paused = 1'b0;
`endif

  always_comb begin
    sync1_d  = i_start_btn;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    // Any cycle matching the accepted level restarts the count.
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    db_rise = db_lvl_d & ~db_lvl_q;
  end

  always_comb begin
    state_d      = state_q;
    frames_d     = frames_q;
    score_d      = score_q;
    press_pend_d = press_pend_q | db_rise;
    hit_pend_d   = (state_q == S_PLAY && !paused) ? (hit_pend_q | i_hit) : 1'b0;
`ifdef GAME_PAUSE_EN
    paused_d     = paused_q;
`endif

    if (state_q == S_PLAY && i_point && !paused && score_q != SCORE_MAX) begin
      score_d = score_q + 1'b1;
    end

    if (i_frame_tick) begin
      press_pend_d = 1'b0;
      hit_pend_d   = 1'b0;
      case (state_q)
        S_TITLE: begin
          if (press_pend_q) begin
            state_d  = S_COUNTDOWN;
            frames_d = CD_INIT;
            score_d  = '0;
          end
        end
        S_COUNTDOWN: begin
          if (frames_q == '0) begin
            state_d = S_PLAY;
          end else begin
            frames_d = frames_q - 1'b1;
          end
        end
        S_PLAY: begin
          if (hit_pend_q) begin
            state_d  = S_OVER;
            frames_d = OV_INIT;
          end
`ifdef GAME_PAUSE_EN
          else if (press_pend_q) begin
            paused_d = ~paused_q;
          end
`endif
        end
        default: begin
          if (press_pend_q || frames_q == '0) begin
            state_d  = S_TITLE;
            frames_d = '0;
          end else begin
            frames_d = frames_q - 1'b1;
          end
        end
      endcase
    end

`ifdef GAME_PAUSE_EN
    if (state_d != S_PLAY) begin
      paused_d = 1'b0;
    end
`endif
    state_chg_d = (state_d != state_q);
  end

  always_ff @(posedge i_clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q      <= S_TITLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      db_lvl_q     <= 1'b0;
      press_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      state_chg_q  <= 1'b0;
      frames_q     <= '0;
      score_q      <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_cnt_q     <= db_cnt_d;
      db_lvl_q     <= db_lvl_d;
      press_pend_q <= press_pend_d;
      hit_pend_q   <= hit_pend_d;
      state_chg_q  <= state_chg_d;
      frames_q     <= frames_d;
      score_q      <= score_d;
    end
  end

`ifdef GAME_PAUSE_EN
  always_ff @(posedge i_clk or negedge RST_BTN) begin
    if (!RST_BTN) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= paused_d;
    end
  end
`endif

  assign o_game_state  = state_q;
  assign o_state_chg   = state_chg_q;
  assign o_frames_left = frames_q;
  assign o_score       = score_q;
  assign o_paused      = paused;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - scoreboard bench for game_state_ctrl
module tb_game_state_ctrl;

  localparam logic [1:0] TITLE = 2'b00, CD = 2'b01, PLAY = 2'b10, OVER = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       point = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] game_state;
  logic       state_chg;
  logic [2:0] frames_left;
  logic [3:0] score;
  logic       paused;

  int total = 0;
  int bad = 0;
  int chg_cnt = 0;
  int chg_mark;

  typedef struct packed {
    logic [1:0] st;
    logic [2:0] fl;
    logic       chg;
  } exp_t;
  exp_t sb_q[$];

  game_state_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .COUNTDOWN_FRAMES(3),
    .OVER_FRAMES     (5),
    .SCORE_W         (4)
  ) dut (
    .i_clk        (clk),
    .RST_BTN      (rst_n),
    .i_start_btn  (start_btn),
    .i_frame_tick (frame_tick),
    .i_point      (point),
    .i_hit        (hit),
    .o_game_state (game_state),
    .o_state_chg  (state_chg),
    .o_frames_left(frames_left),
    .o_score      (score),
    .o_paused     (paused)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (state_chg === 1'b1) chg_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic [1:0] st, input logic [2:0] fl, input logic chg);
    exp_t e;
    frame_tick = 1'b1;
    sb_q.push_back('{st: st, fl: fl, chg: chg});
    @(negedge clk);
    frame_tick = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check("tick_state", 32'(game_state), 32'(e.st));
      check("tick_frames", 32'(frames_left), 32'(e.fl));
      check("tick_chg", 32'(state_chg), 32'(e.chg));
    end
    idle(4);
  endtask

  // Bounces shorter than the debounce window, then a clean press and release.
  task automatic press();
    start_btn = 1'b1; idle(1);
    start_btn = 1'b0; idle(2);
    start_btn = 1'b1; idle(3);
    start_btn = 1'b0; idle(1);
    start_btn = 1'b1; idle(2);
    start_btn = 1'b0; idle(3);
    start_btn = 1'b1; idle(10);
    start_btn = 1'b0; idle(10);
  endtask

  task automatic points(input int n);
    repeat (n) begin
      point = 1'b1; @(negedge clk);
      point = 1'b0; @(negedge clk);
    end
  endtask

  task automatic to_play();
    press();
    tick(CD, 3'd2, 1'b1);
    check("cd_score_clear", 32'(score), 0);
    tick(CD, 3'd1, 1'b0);
    tick(CD, 3'd0, 1'b0);
    tick(PLAY, 3'd0, 1'b1);
  endtask

  initial begin
    frame_tick = 1'b1;
    idle(3);
    check("rst_state", 32'(game_state), 0);
    check("rst_chg", 32'(state_chg), 0);
    check("rst_frames", 32'(frames_left), 0);
    check("rst_score", 32'(score), 0);
    check("rst_paused", 32'(paused), 0);
    frame_tick = 1'b0;
    rst_n = 1'b1;
    idle(2);

    repeat (3) begin
      idle(15);
      tick(TITLE, 3'd0, 1'b0);
    end
    check("title_no_chg", chg_cnt, 0);
    points(2);
    check("title_point", 32'(score), 0);

    press();
    check("press_no_early_chg", chg_cnt, 0);
    tick(CD, 3'd2, 1'b1);
    check("one_chg", chg_cnt, 1);
    press();
    tick(CD, 3'd1, 1'b0);
    tick(CD, 3'd0, 1'b0);
    tick(PLAY, 3'd0, 1'b1);
    tick(PLAY, 3'd0, 1'b0);

    points(20);
    check("score_sat", 32'(score), 15);
    hit = 1'b1; @(negedge clk); hit = 1'b0;
    idle(2);
    tick(OVER, 3'd4, 1'b1);
    tick(OVER, 3'd3, 1'b0);
    tick(OVER, 3'd2, 1'b0);
    tick(OVER, 3'd1, 1'b0);
    tick(OVER, 3'd0, 1'b0);
    tick(TITLE, 3'd0, 1'b1);
    check("score_hold_title", 32'(score), 15);

    to_play();
    points(3);
    point = 1'b1; hit = 1'b1; @(negedge clk);
    point = 1'b0; hit = 1'b0; @(negedge clk);
    check("point_with_hit", 32'(score), 4);
    tick(OVER, 3'd4, 1'b1);
    tick(OVER, 3'd3, 1'b0);
    press();
    tick(TITLE, 3'd0, 1'b1);
    check("score_after_over", 32'(score), 4);

    to_play();
    points(7);
    check("score_seven", 32'(score), 7);
`ifdef GAME_PAUSE_EN
    press();
    tick(PLAY, 3'd0, 1'b0);
    check("paused_on", 32'(paused), 1);
    points(2);
    check("paused_point", 32'(score), 7);
    hit = 1'b1; @(negedge clk); hit = 1'b0;
    tick(PLAY, 3'd0, 1'b0);
    press();
    tick(PLAY, 3'd0, 1'b0);
    check("paused_off", 32'(paused), 0);
`else
    press();
    tick(PLAY, 3'd0, 1'b0);
    check("press_in_play", 32'(paused), 0);
`endif

    chg_mark = chg_cnt;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(game_state), 0);
    check("async_score", 32'(score), 0);
    check("async_frames", 32'(frames_left), 0);
    idle(3);
    rst_n = 1'b1;
    idle(6);
    check("no_chg_release", chg_cnt, chg_mark);
    check("post_rst_state", 32'(game_state), 0);
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
